// File: rtl/decode_stage_hs_pkg.sv
// Shared RV32I/RV32E decode types, opcode constants and small classification helpers
// used by the decode stage, its register file and its interface.
package instruction_utils;

  localparam int unsigned REG_ADDR_W = 5;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [5:0] {
    INSTR_NOP,
    INSTR_LUI, INSTR_AUIPC, INSTR_JAL, INSTR_JALR,
    INSTR_BEQ, INSTR_BNE, INSTR_BLT, INSTR_BGE, INSTR_BLTU, INSTR_BGEU,
    INSTR_LB, INSTR_LH, INSTR_LW, INSTR_LBU, INSTR_LHU,
    INSTR_SB, INSTR_SH, INSTR_SW,
    INSTR_ADDI, INSTR_SLTI, INSTR_SLTIU, INSTR_XORI, INSTR_ORI, INSTR_ANDI,
    INSTR_SLLI, INSTR_SRLI, INSTR_SRAI,
    INSTR_ADD, INSTR_SUB, INSTR_SLL, INSTR_SLT, INSTR_SLTU,
    INSTR_XOR, INSTR_SRL, INSTR_SRA, INSTR_OR, INSTR_AND,
    INSTR_FENCE, INSTR_ECALL, INSTR_EBREAK,
    INSTR_ILLEGAL
  } rv32i_instr_e;

  function automatic logic is_load(rv32i_instr_e t);
    return t inside {INSTR_LB, INSTR_LH, INSTR_LW, INSTR_LBU, INSTR_LHU};
  endfunction

  function automatic logic writes_rd(rv32i_instr_e t);
    return t inside {INSTR_LUI, INSTR_AUIPC, INSTR_JAL, INSTR_JALR,
                     INSTR_LB, INSTR_LH, INSTR_LW, INSTR_LBU, INSTR_LHU,
                     INSTR_ADDI, INSTR_SLTI, INSTR_SLTIU, INSTR_XORI, INSTR_ORI,
                     INSTR_ANDI, INSTR_SLLI, INSTR_SRLI, INSTR_SRAI,
                     INSTR_ADD, INSTR_SUB, INSTR_SLL, INSTR_SLT, INSTR_SLTU,
                     INSTR_XOR, INSTR_SRL, INSTR_SRA, INSTR_OR, INSTR_AND};
  endfunction

endpackage

// File: rtl/decode_stage_hs_if.sv
// Fetch/WB/EXE-facing signal bundle of the decode stage; slave is the stage's view.
interface decode_stage_hs_if
  import instruction_utils::*;
#(
  parameter int unsigned XLEN = 32
);
  logic                  flush;
  logic                  in_valid;
  logic                  in_ready;
  logic [31:0]           instr;
  logic [XLEN-1:0]       pc;
  logic [REG_ADDR_W-1:0] wb_rd_addr;
  logic                  wb_wr_en;
  logic [XLEN-1:0]       wb_rd_data;
  logic                  out_valid;
  logic                  out_ready;
  rv32i_instr_e          instr_type;
  logic [XLEN-1:0]       rs1;
  logic [XLEN-1:0]       rs2;
  logic [REG_ADDR_W-1:0] rs1_addr;
  logic [REG_ADDR_W-1:0] rs2_addr;
  logic [XLEN-1:0]       imm;
  logic [REG_ADDR_W-1:0] rd_addr;
  logic                  write_en;
  logic [XLEN-1:0]       pc_out;
  logic                  hazard;

  modport slave (
    input  flush, in_valid, instr, pc, wb_rd_addr, wb_wr_en, wb_rd_data, out_ready,
    output in_ready, out_valid, instr_type, rs1, rs2, rs1_addr, rs2_addr,
           imm, rd_addr, write_en, pc_out, hazard
  );

  modport master (
    output flush, in_valid, instr, pc, wb_rd_addr, wb_wr_en, wb_rd_data, out_ready,
    input  in_ready, out_valid, instr_type, rs1, rs2, rs1_addr, rs2_addr,
           imm, rd_addr, write_en, pc_out, hazard
  );
endinterface

// File: rtl/decode_stage_hs_decode.sv
// Combinational RV32I decoder: instruction type, register fields, sign-extended immediate.
module rv32i_decoder
  import instruction_utils::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]           instr,
  output rv32i_instr_e          instr_type,
  output logic [REG_ADDR_W-1:0] rs1_addr,
  output logic [REG_ADDR_W-1:0] rs2_addr,
  output logic [REG_ADDR_W-1:0] rd_addr,
  output logic [XLEN-1:0]       imm,
  output logic                  write_en
);
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm32;

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign funct7   = instr[31:25];
  assign rd_addr  = instr[11:7];
  assign rs1_addr = instr[19:15];
  assign rs2_addr = instr[24:20];
  assign imm      = XLEN'($signed(imm32));
  assign write_en = writes_rd(instr_type);

  always_comb begin
    instr_type = INSTR_ILLEGAL;
    imm32      = '0;
    unique case (opcode)
      OPC_LUI: begin
        instr_type = INSTR_LUI;
        imm32      = {instr[31:12], 12'b0};
      end
      OPC_AUIPC: begin
        instr_type = INSTR_AUIPC;
        imm32      = {instr[31:12], 12'b0};
      end
      OPC_JAL: begin
        instr_type = INSTR_JAL;
        imm32      = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      OPC_JALR: begin
        if (funct3 == 3'b000) instr_type = INSTR_JALR;
        imm32 = {{20{instr[31]}}, instr[31:20]};
      end
      OPC_BRANCH: begin
        unique case (funct3)
          3'b000:  instr_type = INSTR_BEQ;
          3'b001:  instr_type = INSTR_BNE;
          3'b100:  instr_type = INSTR_BLT;
          3'b101:  instr_type = INSTR_BGE;
          3'b110:  instr_type = INSTR_BLTU;
          3'b111:  instr_type = INSTR_BGEU;
          default: instr_type = INSTR_ILLEGAL;
        endcase
        imm32 = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      OPC_LOAD: begin
        unique case (funct3)
          3'b000:  instr_type = INSTR_LB;
          3'b001:  instr_type = INSTR_LH;
          3'b010:  instr_type = INSTR_LW;
          3'b100:  instr_type = INSTR_LBU;
          3'b101:  instr_type = INSTR_LHU;
          default: instr_type = INSTR_ILLEGAL;
        endcase
        imm32 = {{20{instr[31]}}, instr[31:20]};
      end
      OPC_STORE: begin
        unique case (funct3)
          3'b000:  instr_type = INSTR_SB;
          3'b001:  instr_type = INSTR_SH;
          3'b010:  instr_type = INSTR_SW;
          default: instr_type = INSTR_ILLEGAL;
        endcase
        imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      OPC_OP_IMM: begin
        imm32 = {{20{instr[31]}}, instr[31:20]};
        unique case (funct3)
          3'b000: instr_type = INSTR_ADDI;
          3'b010: instr_type = INSTR_SLTI;
          3'b011: instr_type = INSTR_SLTIU;
          3'b100: instr_type = INSTR_XORI;
          3'b110: instr_type = INSTR_ORI;
          3'b111: instr_type = INSTR_ANDI;
          3'b001: instr_type = (funct7 == 7'b0000000) ? INSTR_SLLI : INSTR_ILLEGAL;
          default: begin
            if (funct7 == 7'b0000000)      instr_type = INSTR_SRLI;
            else if (funct7 == 7'b0100000) instr_type = INSTR_SRAI;
            else                           instr_type = INSTR_ILLEGAL;
          end
        endcase
      end
      OPC_OP: begin
        unique case ({funct7, funct3})
          10'b0000000_000: instr_type = INSTR_ADD;
          10'b0100000_000: instr_type = INSTR_SUB;
          10'b0000000_001: instr_type = INSTR_SLL;
          10'b0000000_010: instr_type = INSTR_SLT;
          10'b0000000_011: instr_type = INSTR_SLTU;
          10'b0000000_100: instr_type = INSTR_XOR;
          10'b0000000_101: instr_type = INSTR_SRL;
          10'b0100000_101: instr_type = INSTR_SRA;
          10'b0000000_110: instr_type = INSTR_OR;
          10'b0000000_111: instr_type = INSTR_AND;
          default:         instr_type = INSTR_ILLEGAL;
        endcase
      end
      OPC_MISC_MEM: instr_type = INSTR_FENCE;
      OPC_SYSTEM: begin
        if (instr[31:7] == 25'h0000000)      instr_type = INSTR_ECALL;
        else if (instr[31:7] == 25'h0002000) instr_type = INSTR_EBREAK;
        else                                 instr_type = INSTR_ILLEGAL;
      end
      default: instr_type = INSTR_ILLEGAL;
    endcase
  end
endmodule

// File: rtl/decode_stage_hs_regfile.sv
// Two-read/one-write register file; x0 and out-of-range addresses read 0 and ignore writes,
// and a same-cycle write to a read address is forwarded to that read port.
module register_file_wt
  import instruction_utils::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NUM_REGS = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] rd_addr_a,
  output logic [XLEN-1:0]       rd_data_a,
  input  logic [REG_ADDR_W-1:0] rd_addr_b,
  output logic [XLEN-1:0]       rd_data_b,
  input  logic                  wr_en,
  input  logic [REG_ADDR_W-1:0] wr_addr,
  input  logic [XLEN-1:0]       wr_data
);
  localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic [XLEN-1:0] regs_q [NUM_REGS];
  logic [XLEN-1:0] regs_d [NUM_REGS];
  logic            wr_ok;

  function automatic logic addr_live(logic [REG_ADDR_W-1:0] a);
    return (a != '0) && (32'(a) < NUM_REGS);
  endfunction

  assign wr_ok = wr_en && addr_live(wr_addr);

  always_comb begin
    regs_d = regs_q;
    if (wr_ok) regs_d[wr_addr[IDX_W-1:0]] = wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) regs_q <= '{default: '0};
    else     regs_q <= regs_d;
  end

  always_comb begin
    rd_data_a = '0;
    if (addr_live(rd_addr_a)) begin
      if (wr_ok && (wr_addr == rd_addr_a)) rd_data_a = wr_data;
      else                                 rd_data_a = regs_q[rd_addr_a[IDX_W-1:0]];
    end
  end

  always_comb begin
    rd_data_b = '0;
    if (addr_live(rd_addr_b)) begin
      if (wr_ok && (wr_addr == rd_addr_b)) rd_data_b = wr_data;
      else                                 rd_data_b = regs_q[rd_addr_b[IDX_W-1:0]];
    end
  end
endmodule

// File: rtl/decode_stage_hs.sv
// ID stage: decodes one instruction per fetch handshake into a registered slot toward EXE,
// with load-use bubbles, flush, and WB refresh of operands held under backpressure.
module decode_stage_hs
  import instruction_utils::*;
#(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned NUM_REGS       = 32,
  parameter int unsigned LOAD_USE_CHECK = 1
) (
  input  logic             clk,
  input  logic             rst,
  decode_stage_hs_if.slave bus
);
  rv32i_instr_e          dec_type;
  logic [REG_ADDR_W-1:0] dec_rs1, dec_rs2, dec_rd;
  logic [XLEN-1:0]       dec_imm;
  logic                  dec_we;
  logic [XLEN-1:0]       rf_rs1, rf_rs2;

  logic                  out_valid_q,  out_valid_d;
  rv32i_instr_e          instr_type_q, instr_type_d;
  logic [XLEN-1:0]       rs1_q,        rs1_d;
  logic [XLEN-1:0]       rs2_q,        rs2_d;
  logic [REG_ADDR_W-1:0] rs1_addr_q,   rs1_addr_d;
  logic [REG_ADDR_W-1:0] rs2_addr_q,   rs2_addr_d;
  logic [XLEN-1:0]       imm_q,        imm_d;
  logic [REG_ADDR_W-1:0] rd_addr_q,    rd_addr_d;
  logic                  write_en_q,   write_en_d;
  logic [XLEN-1:0]       pc_q,         pc_d;

  logic hazard, in_ready, fire_in, fire_out, wb_live;

  rv32i_decoder #(.XLEN(XLEN)) u_dec (
    .instr      (bus.instr),
    .instr_type (dec_type),
    .rs1_addr   (dec_rs1),
    .rs2_addr   (dec_rs2),
    .rd_addr    (dec_rd),
    .imm        (dec_imm),
    .write_en   (dec_we)
  );

  register_file_wt #(.XLEN(XLEN), .NUM_REGS(NUM_REGS)) u_rf (
    .clk       (clk),
    .rst       (rst),
    .rd_addr_a (dec_rs1),
    .rd_data_a (rf_rs1),
    .rd_addr_b (dec_rs2),
    .rd_data_b (rf_rs2),
    .wr_en     (bus.wb_wr_en),
    .wr_addr   (bus.wb_rd_addr),
    .wr_data   (bus.wb_rd_data)
  );

  // Compares raw rs fields even for formats that do not use them: cheaper, never unsafe.
  assign hazard = (LOAD_USE_CHECK != 0) && out_valid_q && is_load(instr_type_q) &&
                  write_en_q && (rd_addr_q != '0) && bus.in_valid &&
                  ((rd_addr_q == dec_rs1) || (rd_addr_q == dec_rs2));

  assign in_ready = (!out_valid_q || bus.out_ready) && !hazard && !bus.flush;
  assign fire_in  = bus.in_valid && in_ready;
  assign fire_out = out_valid_q && bus.out_ready;
  assign wb_live  = bus.wb_wr_en && (bus.wb_rd_addr != '0);

  always_comb begin
    out_valid_d  = out_valid_q;
    instr_type_d = instr_type_q;
    rs1_d        = rs1_q;
    rs2_d        = rs2_q;
    rs1_addr_d   = rs1_addr_q;
    rs2_addr_d   = rs2_addr_q;
    imm_d        = imm_q;
    rd_addr_d    = rd_addr_q;
    write_en_d   = write_en_q;
    pc_d         = pc_q;
    if (bus.flush) begin
      out_valid_d  = 1'b0;
      instr_type_d = INSTR_NOP;
    end else if (fire_in) begin
      out_valid_d  = 1'b1;
      instr_type_d = dec_type;
      rs1_d        = rf_rs1;
      rs2_d        = rf_rs2;
      rs1_addr_d   = dec_rs1;
      rs2_addr_d   = dec_rs2;
      imm_d        = dec_imm;
      rd_addr_d    = dec_rd;
      write_en_d   = dec_we;
      pc_d         = bus.pc;
    end else if (fire_out) begin
      out_valid_d  = 1'b0;
      instr_type_d = INSTR_NOP;
    end else if (out_valid_q) begin
      if (wb_live && (bus.wb_rd_addr == rs1_addr_q)) rs1_d = bus.wb_rd_data;
      if (wb_live && (bus.wb_rd_addr == rs2_addr_q)) rs2_d = bus.wb_rd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      instr_type_q <= INSTR_NOP;
      rs1_q        <= '0;
      rs2_q        <= '0;
      rs1_addr_q   <= '0;
      rs2_addr_q   <= '0;
      imm_q        <= '0;
      rd_addr_q    <= '0;
      write_en_q   <= 1'b0;
      pc_q         <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      instr_type_q <= instr_type_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      rs1_addr_q   <= rs1_addr_d;
      rs2_addr_q   <= rs2_addr_d;
      imm_q        <= imm_d;
      rd_addr_q    <= rd_addr_d;
      write_en_q   <= write_en_d;
      pc_q         <= pc_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.hazard     = hazard;
  assign bus.out_valid  = out_valid_q;
  assign bus.instr_type = instr_type_q;
  assign bus.rs1        = rs1_q;
  assign bus.rs2        = rs2_q;
  assign bus.rs1_addr   = rs1_addr_q;
  assign bus.rs2_addr   = rs2_addr_q;
  assign bus.imm        = imm_q;
  assign bus.rd_addr    = rd_addr_q;
  assign bus.write_en   = write_en_q;
  assign bus.pc_out     = pc_q;
endmodule

// File: tb/tb_decode_stage_hs.sv
// Directed bench for decode_stage_hs: a default RV32I instance and an RV32E instance
// with the load-use check disabled.
module tb_decode_stage_hs;
  import instruction_utils::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  always #5 clk = ~clk;

  decode_stage_hs_if #(.XLEN(32)) b   ();
  decode_stage_hs_if #(.XLEN(32)) b16 ();

  decode_stage_hs #(.XLEN(32), .NUM_REGS(32), .LOAD_USE_CHECK(1)) dut (
    .clk (clk), .rst (rst), .bus (b.slave)
  );

  decode_stage_hs #(.XLEN(32), .NUM_REGS(16), .LOAD_USE_CHECK(0)) dut16 (
    .clk (clk), .rst (rst), .bus (b16.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    {b.flush, b.in_valid, b.instr, b.pc, b.wb_rd_addr, b.wb_wr_en, b.wb_rd_data, b.out_ready} = '0;
    {b16.flush, b16.in_valid, b16.instr, b16.pc, b16.wb_rd_addr, b16.wb_wr_en,
     b16.wb_rd_data, b16.out_ready} = '0;
    step();
    step();
    rst = 1'b0;
    #1;
    check("rst_out_valid", 32'(b.out_valid), 32'd0);
    check("rst_type",      32'(b.instr_type), 32'(INSTR_NOP));
    check("rst_hazard",    32'(b.hazard), 32'd0);
    check("rst_rs1",       b.rs1, 32'd0);
    check("rst_imm",       b.imm, 32'd0);
    check("rst_pc",        b.pc_out, 32'd0);
    check("rst_in_ready",  32'(b.in_ready), 32'd1);

    // addi x1,x0,5
    b.instr = 32'h00500093; b.pc = 32'h100; b.in_valid = 1'b1; b.out_ready = 1'b1;
    step();
    check("t1_valid", 32'(b.out_valid), 32'd1);
    check("t1_type",  32'(b.instr_type), 32'(INSTR_ADDI));
    check("t1_rd",    32'(b.rd_addr), 32'd1);
    check("t1_imm",   b.imm, 32'd5);
    check("t1_rs1",   b.rs1, 32'd0);
    check("t1_we",    32'(b.write_en), 32'd1);
    check("t1_haz",   32'(b.hazard), 32'd0);
    check("t1_pc",    b.pc_out, 32'h100);
    b.in_valid = 1'b0;
    step();
    check("t1_drain_valid", 32'(b.out_valid), 32'd0);
    check("t1_drain_type",  32'(b.instr_type), 32'(INSTR_NOP));

    // add x3,x2,x2 while WB writes x2
    b.instr = 32'h002101B3; b.in_valid = 1'b1;
    b.wb_wr_en = 1'b1; b.wb_rd_addr = 5'd2; b.wb_rd_data = 32'hDEAD;
    step();
    check("t2_rs1",  b.rs1, 32'hDEAD);
    check("t2_rs2",  b.rs2, 32'hDEAD);
    check("t2_type", 32'(b.instr_type), 32'(INSTR_ADD));
    b.wb_wr_en = 1'b0;

    // add x3,x1,x2 held under backpressure while WB writes x1
    b.instr = 32'h002081B3;
    step();
    check("t3_rs1_pre", b.rs1, 32'd0);
    b.in_valid = 1'b0; b.out_ready = 1'b0;
    b.wb_wr_en = 1'b1; b.wb_rd_addr = 5'd1; b.wb_rd_data = 32'h77;
    step();
    b.wb_wr_en = 1'b0;
    step();
    step();
    check("t3_valid",    32'(b.out_valid), 32'd1);
    check("t3_in_ready", 32'(b.in_ready), 32'd0);
    check("t3_rs1",      b.rs1, 32'h77);
    check("t3_rs2",      b.rs2, 32'hDEAD);
    b.out_ready = 1'b1;
    step();
    check("t3_drained", 32'(b.out_valid), 32'd0);

    // lw x5,0(x0) then add x6,x5,x0
    b.instr = 32'h00002283; b.in_valid = 1'b1;
    step();
    check("t4_lw_type", 32'(b.instr_type), 32'(INSTR_LW));
    b.instr = 32'h00028333;
    #1;
    check("t4_hazard",   32'(b.hazard), 32'd1);
    check("t4_in_ready", 32'(b.in_ready), 32'd0);
    step();
    check("t4_bubble",       32'(b.out_valid), 32'd0);
    check("t4_hazard_clear", 32'(b.hazard), 32'd0);
    check("t4_in_ready_up",  32'(b.in_ready), 32'd1);
    step();
    b.in_valid = 1'b0;
    check("t4_add_valid", 32'(b.out_valid), 32'd1);
    check("t4_add_type",  32'(b.instr_type), 32'(INSTR_ADD));
    check("t4_add_rd",    32'(b.rd_addr), 32'd6);
    check("t4_add_rs1a",  32'(b.rs1_addr), 32'd5);

    // flush with a valid slot and an offered addi x7,x0,5
    b.out_ready = 1'b0; b.flush = 1'b1; b.in_valid = 1'b1; b.instr = 32'h00500393;
    #1;
    check("t5_in_ready", 32'(b.in_ready), 32'd0);
    step();
    check("t5_valid", 32'(b.out_valid), 32'd0);
    check("t5_type",  32'(b.instr_type), 32'(INSTR_NOP));
    b.flush = 1'b0; b.in_valid = 1'b0;
    step();
    check("t5_not_captured", 32'(b.out_valid), 32'd0);

    // sw x2,-4(x1)
    b.out_ready = 1'b1; b.in_valid = 1'b1; b.instr = 32'hFE20AE23;
    step();
    b.in_valid = 1'b0;
    check("sw_type", 32'(b.instr_type), 32'(INSTR_SW));
    check("sw_imm",  b.imm, 32'hFFFFFFFC);
    check("sw_we",   32'(b.write_en), 32'd0);
    check("sw_rs1",  b.rs1, 32'h77);
    check("sw_rs2",  b.rs2, 32'hDEAD);

    // RV32E instance: out-of-range and x0 writes, top in-range register
    b16.out_ready = 1'b1;
    b16.wb_wr_en = 1'b1; b16.wb_rd_addr = 5'd20; b16.wb_rd_data = 32'h1234;
    step();
    b16.wb_wr_en = 1'b0;
    b16.in_valid = 1'b1; b16.instr = 32'h000A00B3;
    step();
    check("e_x20_rs1",  b16.rs1, 32'd0);
    check("e_x20_addr", 32'(b16.rs1_addr), 32'd20);
    b16.instr = 32'h00000133;
    b16.wb_wr_en = 1'b1; b16.wb_rd_addr = 5'd0; b16.wb_rd_data = 32'h55;
    step();
    check("e_x0_wt", b16.rs1, 32'd0);
    b16.wb_wr_en = 1'b0;
    step();
    check("e_x0_read", b16.rs1, 32'd0);
    b16.instr = 32'h000781B3;
    b16.wb_wr_en = 1'b1; b16.wb_rd_addr = 5'd15; b16.wb_rd_data = 32'hABCD;
    step();
    check("e_x15_wt", b16.rs1, 32'hABCD);
    b16.wb_wr_en = 1'b0;
    step();
    check("e_x15_read", b16.rs1, 32'hABCD);

    // load-use check disabled: no bubble
    b16.instr = 32'h00002283;
    step();
    b16.instr = 32'h00028333;
    #1;
    check("e_no_hazard",   32'(b16.hazard), 32'd0);
    check("e_in_ready",    32'(b16.in_ready), 32'd1);
    step();
    b16.in_valid = 1'b0;
    check("e_add_type", 32'(b16.instr_type), 32'(INSTR_ADD));
    check("e_add_rd",   32'(b16.rd_addr), 32'd6);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/decode_stage_hs.md
Name: decode_stage_hs

Overview:
Parametrised successor of the ID stage.
- Decodes one RV32I/RV32E instruction per handshake and reads operands from an internal parametrised register file with WB write-through.
- Registers the results into an output slot with valid/ready flow control toward EXE.
- Adds load-use bubble insertion, flush, and refresh of held operands on WB writes.
- Sits between fetch (upstream valid/ready) and execute (downstream valid/ready).

Parameters:
XLEN, 32, datapath width of operands, imm and PC.
NUM_REGS, 32, architectural registers: 32 for RV32I, 16 for RV32E.
LOAD_USE_CHECK, 1, 1 enables load-use bubble insertion; 0 disables it and hazard is tied to 0.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
flush  in  1  discard the held and incoming instruction
in_valid  in  1  fetch offers instr/pc
in_ready  out  1  ID accepts this cycle
instr  in  32  raw instruction
pc  in  XLEN  instruction address
wb_rd_addr  in  5  WB destination
wb_wr_en  in  1  WB write enable
wb_rd_data  in  XLEN  WB data
out_valid  out  1  output slot holds an instruction
out_ready  in  1  EXE accepts this cycle
instr_type  out  rv32i_instr_e  decoded type
rs1, rs2  out  XLEN each  operand values
rs1_addr, rs2_addr  out  5 each  operand addresses, for EXE forwarding
imm  out  XLEN  sign-extended immediate
rd_addr  out  5  destination
write_en  out  1  rd write enable
pc_out  out  XLEN  registered pc
hazard  out  1  load-use bubble being inserted this cycle

Behaviour:
- Reset:
  - out_valid=0, instr_type=INSTR_NOP, hazard=0.
  - All other outputs 0.
  - All registers 0. Reset mid-stream drops the held instruction.
- Register file:
  - x0 reads 0; writes to x0 are ignored.
  - Addresses >= NUM_REGS: writes ignored, reads return 0.
  - Write occurs at posedge when wb_wr_en.
  - Read is combinational with write-through: if wb_wr_en and wb_rd_addr==read addr (non-zero, in range), return wb_rd_data.
- Handshake:
  - fire_in = in_valid && in_ready.
  - fire_out = out_valid && out_ready.
  - in_ready = (!out_valid || out_ready) && !hazard && !flush.
  - Latency 1: fire_in at cycle N gives out_valid=1 with all fields at N+1.
- Output slot next state:
  - If fire_in: load the decoded fields, operands and pc.
  - Else if fire_out: out_valid<=0 (fields may hold stale values, but instr_type<=INSTR_NOP).
  - Else: hold.
- Held-operand refresh:
  - Applies while out_valid && !fire_out.
  - If wb_wr_en && wb_rd_addr!=0 && wb_rd_addr==rs1_addr, then rs1<=wb_rd_data. Same rule for rs2.
  - Prevents stale operands under backpressure.
- Load-use hazard:
  - hazard = LOAD_USE_CHECK && out_valid && is_load(instr_type) && write_en && rd_addr!=0 && in_valid && (rd_addr==dec_rs1 || rd_addr==dec_rs2).
  - The comparison is conservative: formats with unused rs fields still compare.
  - When hazard && out_ready: the load leaves, the slot becomes a bubble (out_valid=0) and the instruction stays upstream.
  - Next cycle hazard is 0 and the instruction is accepted. Penalty is exactly 1 cycle.
- Flush:
  - Synchronously sets out_valid<=0 and instr_type<=INSTR_NOP; in_ready=0 that cycle.
  - Flush overrides fire_in and refresh.
  - WB writes still commit during flush.
- Simultaneous events: a WB write to the same address as a fire_in read delivers the new value via write-through.

Decomposition:
- Package instruction_utils:
  - Extend rv32i_instr_e if needed.
  - Add function is_load(rv32i_instr_e), covering LB/LH/LW/LBU/LHU.
  - Add localparam REG_ADDR_W=5.
- Reuse the existing combinational decode module unchanged.
- One new sub-module, register_file_wt: parameters XLEN and NUM_REGS, two read ports with write-through, one write port, range/x0 masking.
- Hazard, refresh and slot logic live in decode_stage_hs.

Test Plan:
1. Reset, then addi x1,x0,5 (0x00500093) with in_valid=1, out_ready=1 → next cycle out_valid=1, rd_addr=1, imm=5, rs1=0, write_en=1, hazard=0.
2. WB writes x2=0xDEAD in the same cycle add x3,x2,x2 fires → rs1=rs2=0xDEAD (write-through).
3. add x3,x1,x2 held with out_ready=0 for 3 cycles while WB writes x1=0x77 → rs1=0x77 when out_ready rises; rs2 unchanged.
4. lw x5,0(x0) in slot, add x6,x5,x0 offered, out_ready=1 → hazard=1 and in_ready=0 for exactly 1 cycle, bubble (out_valid=0), add accepted the next cycle.
5. flush=1 with slot valid and in_valid=1 → out_valid=0, instr_type=INSTR_NOP, in_ready=0, incoming instruction not captured.
6. NUM_REGS=16: WB writes x20=0x1234, then add x1,x20,x0 → rs1=0; writes to x0 are ignored and read back 0.
